// File: rtl/des_pkg.sv
// Shared DES definitions: state encoding, rotation schedules, permutation tables and S-boxes.
// Bit 63 of a 64-bit word is DES bit 1; every table lists 1-based DES bit numbers.
package des_pkg;

    typedef enum logic {IDLE, ROUND} state_t;

    // Decrypt walks the key schedule backwards, so its first round uses no rotation.
    localparam logic [31:0] RSHIFT = {2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    localparam logic [31:0] LSHIFT = {2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5,     4,5,6,7,8,9,       8,9,10,11,12,13,
                                12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,  1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27,  19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29,  21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5,   3,28,15,6,21,10,  23,19,12,4,26,8,
                                  16,7,27,20,13,2,   41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};

    // One 256-bit word per box: 64 nibbles, row-major, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    // Outer bits pick the row, inner four bits pick the column.
    function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
        logic [5:0]   idx;
        logic [255:0] tbl;
        idx = {b[5], b[0], b[4:1]};
        tbl = SBOX[n];
        return tbl[8'(255 - 4 * int'(idx)) -: 4];
    endfunction

    function automatic logic [1:0] rshift_amt(input logic [3:0] rnd);
        return RSHIFT[5'(31 - 2 * int'(rnd)) -: 2];
    endfunction

    function automatic logic [1:0] lshift_amt(input logic [3:0] rnd);
        return LSHIFT[5'(31 - 2 * int'(rnd)) -: 2];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_f.sv
// DES round function f(R,K): expand, mix in the subkey, substitute through S1..S8, permute.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    logic [47:0] x;
    logic [31:0] s;

    assign x = e_expand(r) ^ k;

    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s[31 - 4 * g -: 4] = sbox(3'(g), x[47 - 6 * g -: 6]);
    end

    assign f = p_perm(s);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, 16 rounds per block, start/busy/done handshake.
module des_decrypt_core
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic [63:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] data_out
);

    state_t      state;
    logic [31:0] l, r;
    logic [27:0] c, d;
    logic [3:0]  rnd;

    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] f_out, r_next;

    // Right rotation walks the encryption schedule backwards, yielding K16 down to K1.
    assign c_rot  = rotr28(c, rshift_amt(rnd));
    assign d_rot  = rotr28(d, rshift_amt(rnd));
    assign subkey = pc2({c_rot, d_rot});
    assign r_next = l ^ f_out;

    des_f u_f (
        .r (r),
        .k (subkey),
        .f (f_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            l        <= '0;
            r        <= '0;
            c        <= '0;
            d        <= '0;
            rnd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        {l, r} <= ip(data_in);
                        {c, d} <= pc1(key);
                        rnd    <= '0;
                        busy   <= 1'b1;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    l   <= r;
                    r   <= r_next;
                    c   <= c_rot;
                    d   <= d_rot;
                    rnd <= rnd + 4'd1;
                    // Final round: output swaps the halves before the inverse initial permutation.
                    if (rnd == 4'd15) begin
                        data_out <= fp({r_next, r});
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
